// File: rtl/stride_pkg.sv
// stride_pkg: shared types and helpers for the stride decimator.
//   stride_e      run-time stride codes (1, 2, 4, reserved)
//   state_e       control FSM encodings
//   ceil_div_pow2 ceil(n / stride) without a divider
package stride_pkg;

   typedef enum logic [1:0] {
      STRIDE_1    = 2'd0,
      STRIDE_2    = 2'd1,
      STRIDE_4    = 2'd2,
      STRIDE_RSVD = 2'd3
   } stride_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int CNT_W = 16;

   // Shift down and round up when any shifted-out bit was set.
   function automatic logic [CNT_W-1:0] ceil_div_pow2(input logic [CNT_W-1:0] n,
                                                      input logic [1:0]       code);
      logic [CNT_W-1:0] r;
      case (code)
         STRIDE_2: r = (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
         STRIDE_4: r = (n >> 2) + {{(CNT_W-1){1'b0}}, |n[1:0]};
         default:  r = n;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/stride_sync_fifo.sv
// stride_sync_fifo: show-ahead synchronous FIFO, depth 2**FIFO_ADDR_BITS.
//   clk/rst   clock, async active-low reset
//   wr_en/wr_data  push side (ignored when full)
//   rd_en     pop the head entry (ignored when empty)
//   rd_data   head entry, valid whenever !empty; 0 when empty
//   empty     no entries held
//   free_cnt  number of unused entries
module stride_sync_fifo #(
   parameter int WIDTH          = 64,
   parameter int FIFO_ADDR_BITS = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      empty,
   output logic [FIFO_ADDR_BITS:0]   free_cnt
);
   localparam int AW = FIFO_ADDR_BITS;
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             wr_ok, rd_ok;

   assign empty    = (count_q == '0);
   assign wr_ok    = wr_en & (count_q != DEPTH);
   assign rd_ok    = rd_en & ~empty;
   assign free_cnt = DEPTH - count_q;
   // Gate the head so the output reads 0 while nothing is held.
   assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers wrap naturally modulo depth.
         if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/stride_decimator.sv
// stride_decimator: drops feature-map pixels by a run-time stride of 1/2/4.
//   Start + *_REG   config, latched on Start in IDLE
//   S_*             input beat stream (channel group fastest, then col, row)
//   M_*             kept beats through a show-ahead FIFO
//   Last            final output beat of the frame
//   Busy            RUN or DRAIN
//   Stride_Complete pulse after the final input beat is accepted
//   Cfg_Err         pulse after a Start with an invalid config
module stride_decimator
   import stride_pkg::*;
#(
   parameter int CHANNEL_OUT_NUM       = 8,
   parameter int BEAT_WIDTH            = 64,
   parameter int WIDTH_CHANNEL_NUM_REG = 10,
   parameter int WIDTH_FEATURE_SIZE    = 12,
   parameter int FIFO_ADDR_BITS        = 9
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             Start,
   input  logic [1:0]                       Stride_REG,
   input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_In_REG,
   input  logic [WIDTH_FEATURE_SIZE-1:0]    Col_Num_In_REG,
   input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
   input  logic [BEAT_WIDTH-1:0]            S_Data,
   input  logic                             S_Valid,
   output logic                             S_Ready,
   output logic [BEAT_WIDTH-1:0]            M_Data,
   output logic                             M_Valid,
   input  logic                             M_Ready,
   output logic                             Last,
   output logic                             Busy,
   output logic                             Stride_Complete,
   output logic                             Cfg_Err
);
   localparam int WC       = WIDTH_CHANNEL_NUM_REG;
   localparam int WF       = WIDTH_FEATURE_SIZE;
   localparam int AW       = FIFO_ADDR_BITS;
   localparam int CG_SHIFT = $clog2(CHANNEL_OUT_NUM);

   state_e         state_q, state_d;
   stride_e        stride_q;
   logic [WC-1:0]  ct_last_q, cnt_cin_q, m_cin_q, cfg_ct;
   logic [WF-1:0]  col_last_q, row_last_q, ocol_last_q, orow_last_q;
   logic [WF-1:0]  cnt_col_q, cnt_row_q, m_col_q, m_row_q, keep_mask;
   logic           out_done_q, wr_vld_q, cmpl_q, cfg_err_q;
   logic [BEAT_WIDTH-1:0] wr_data_q;
   logic           cfg_ok, start_ok, start_bad;
   logic           in_fire, cin_wrap, col_wrap, in_final, keep;
   logic           out_fire, m_cin_wrap, m_col_wrap, fifo_empty;
   logic [AW:0]    free_cnt;

   assign cfg_ct    = Channel_Out_Num_REG >> CG_SHIFT;
   assign cfg_ok    = (Stride_REG != STRIDE_RSVD) && (Row_Num_In_REG != '0) &&
                      (Col_Num_In_REG != '0) && (cfg_ct != '0);
   assign start_ok  = Start && (state_q == ST_IDLE) && cfg_ok;
   assign start_bad = Start && (state_q == ST_IDLE) && !cfg_ok;

   // Two free entries: one for the beat in the register stage, one for this one.
   assign S_Ready  = (state_q == ST_RUN) && (free_cnt >= (AW+1)'(2));
   assign in_fire  = S_Valid & S_Ready;
   assign cin_wrap = (cnt_cin_q == ct_last_q);
   assign col_wrap = (cnt_col_q == col_last_q);
   assign in_final = cin_wrap & col_wrap & (cnt_row_q == row_last_q);

   // Stride is a power of two, so "mod S == 0" is a test of the low bits.
   always_comb begin
      keep_mask = '0;
      case (stride_q)
         STRIDE_2: keep_mask = WF'(1);
         STRIDE_4: keep_mask = WF'(3);
         default:  keep_mask = '0;
      endcase
   end
   assign keep = ((cnt_col_q & keep_mask) == '0) && ((cnt_row_q & keep_mask) == '0);

   assign M_Valid    = ~fifo_empty;
   assign out_fire   = M_Valid & M_Ready;
   assign m_cin_wrap = (m_cin_q == ct_last_q);
   assign m_col_wrap = (m_col_q == ocol_last_q);
   assign Last       = M_Valid & m_cin_wrap & m_col_wrap & (m_row_q == orow_last_q);

   assign Busy            = (state_q != ST_IDLE);
   assign Stride_Complete = cmpl_q;
   assign Cfg_Err         = cfg_err_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_RUN;
         ST_RUN:   if (in_fire && in_final) state_d = ST_DRAIN;
         // When the last input pixel is dropped, the Last beat may already
         // have left during RUN; out_done_q remembers that.
         ST_DRAIN: if (out_done_q || (out_fire && Last)) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         stride_q    <= STRIDE_1;
         ct_last_q   <= '0;
         col_last_q  <= '0;
         row_last_q  <= '0;
         ocol_last_q <= '0;
         orow_last_q <= '0;
         cnt_cin_q   <= '0;
         cnt_col_q   <= '0;
         cnt_row_q   <= '0;
         m_cin_q     <= '0;
         m_col_q     <= '0;
         m_row_q     <= '0;
         out_done_q  <= 1'b0;
         wr_vld_q    <= 1'b0;
         wr_data_q   <= '0;
         cmpl_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmpl_q    <= in_fire & in_final;
         cfg_err_q <= start_bad;
         wr_vld_q  <= in_fire & keep;
         if (in_fire & keep) wr_data_q <= S_Data;
         if (start_ok) begin
            stride_q    <= stride_e'(Stride_REG);
            ct_last_q   <= cfg_ct - WC'(1);
            col_last_q  <= Col_Num_In_REG - WF'(1);
            row_last_q  <= Row_Num_In_REG - WF'(1);
            ocol_last_q <= WF'(ceil_div_pow2(CNT_W'(Col_Num_In_REG), Stride_REG)) - WF'(1);
            orow_last_q <= WF'(ceil_div_pow2(CNT_W'(Row_Num_In_REG), Stride_REG)) - WF'(1);
            cnt_cin_q   <= '0;
            cnt_col_q   <= '0;
            cnt_row_q   <= '0;
            m_cin_q     <= '0;
            m_col_q     <= '0;
            m_row_q     <= '0;
            out_done_q  <= 1'b0;
         end else begin
            if (in_fire) begin
               cnt_cin_q <= cin_wrap ? '0 : cnt_cin_q + WC'(1);
               if (cin_wrap) begin
                  cnt_col_q <= col_wrap ? '0 : cnt_col_q + WF'(1);
                  if (col_wrap) cnt_row_q <= cnt_row_q + WF'(1);
               end
            end
            if (out_fire) begin
               m_cin_q <= m_cin_wrap ? '0 : m_cin_q + WC'(1);
               if (m_cin_wrap) begin
                  m_col_q <= m_col_wrap ? '0 : m_col_q + WF'(1);
                  if (m_col_wrap) m_row_q <= m_row_q + WF'(1);
               end
               if (Last) out_done_q <= 1'b1;
            end
         end
      end
   end

   stride_sync_fifo #(
      .WIDTH          (BEAT_WIDTH),
      .FIFO_ADDR_BITS (FIFO_ADDR_BITS)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_vld_q),
      .wr_data  (wr_data_q),
      .rd_en    (out_fire),
      .rd_data  (M_Data),
      .empty    (fifo_empty),
      .free_cnt (free_cnt)
   );

endmodule

// File: doc/stride_decimator.md
# stride_decimator

Parametrised successor of the fixed stride-2 output stage; sits between the convolution/quantisation output and the output DMA. Drops feature-map pixels according to a run-time stride of 1, 2 or 4 on a rectangular map. Passes kept beats through a show-ahead FIFO with AXI-Stream-style handshakes. Generates `Last` on the final output beat and a completion pulse when the final input beat is consumed.

## Interface
- `CHANNEL_OUT_NUM`, 8: channels per beat; power of two.
- `BEAT_WIDTH`, 64: data bits per beat.
- `WIDTH_CHANNEL_NUM_REG`, 10: width of the channel-count register.
- `WIDTH_FEATURE_SIZE`, 12: width of row/column counts.
- `FIFO_ADDR_BITS`, 9: log2 of the output FIFO depth.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `Start`  in  1  one-cycle pulse; latches config; ignored unless IDLE.
- `Stride_REG`  in  2  0 = stride 1, 1 = stride 2, 2 = stride 4, 3 = reserved.
- `Row_Num_In_REG`  in  `WIDTH_FEATURE_SIZE`  input rows.
- `Col_Num_In_REG`  in  `WIDTH_FEATURE_SIZE`  input columns.
- `Channel_Out_Num_REG`  in  `WIDTH_CHANNEL_NUM_REG`  channels; must be a multiple of `CHANNEL_OUT_NUM`.
- `S_Data`  in  `BEAT_WIDTH`  input beat.
- `S_Valid`  in  1  input beat valid.
- `S_Ready`  out  1  input ready.
- `M_Data`  out  `BEAT_WIDTH`  output beat.
- `M_Valid`  out  1  output valid.
- `M_Ready`  in  1  output ready.
- `Last`  out  1  high with the final output beat.
- `Busy`  out  1  high in RUN or DRAIN.
- `Stride_Complete`  out  1  one-cycle pulse after the final input beat is accepted.
- `Cfg_Err`  out  1  one-cycle pulse on a rejected Start.

## Operation
- CT (channel times) = `Channel_Out_Num_REG >> log2(CHANNEL_OUT_NUM)`. S = 1, 2 or 4.
- Output rows = ceil(R/S); output columns = ceil(C/S). Total output beats = out_rows * out_cols * CT.
- Input order is channel group fastest, then column, then row.
- States:
  - IDLE → RUN on Start with a valid config. Config registers and all counters are loaded and cleared.
  - IDLE on Start with an invalid config (R = 0, C = 0, CT = 0, or Stride_REG = 3): stay in IDLE and pulse `Cfg_Err` the next cycle.
  - RUN → DRAIN when the final input beat is accepted. That beat is accepted at cnt_cin = CT-1, cnt_col = C-1, cnt_row = R-1.
  - DRAIN → IDLE when the output beat with `Last` completes its handshake.
- A beat is accepted when `S_Valid & S_Ready`. Counters advance only on an accepted beat.
  - cnt_cin wraps at CT-1.
  - cnt_col increments on the cin wrap and wraps at C-1.
  - cnt_row increments on the column wrap.
- A beat is kept when (cnt_col mod S) == 0 and (cnt_row mod S) == 0. Use the low bits of each counter; no divider. Dropped beats are still accepted.
- Kept beats go through one register stage into the FIFO.
- `S_Ready` = RUN and free FIFO entries ≥ 2; the 2-entry margin covers the register stage. `S_Ready` is 0 in IDLE and DRAIN.
- Output counters (m_cin, m_col, m_row) advance on `M_Valid & M_Ready`. `Last` = (m_cin == CT-1) & (m_col == out_cols-1) & (m_row == out_rows-1) & `M_Valid`.
- Stride 1 passes every beat unchanged.

## Timing
- Reset values: `S_Ready`, `M_Valid`, `Last`, `Busy`, `Stride_Complete`, `Cfg_Err` all 0. `M_Data` is 0. State is IDLE. FIFO is empty.
- Latency: a kept beat accepted in cycle t is written at the t+1 edge. `M_Valid` is high in cycle t+2.
- `Busy` rises the cycle after an accepted Start.
- `Stride_Complete` is high in the cycle after the final input acceptance, for exactly one cycle.
- `M_Data` and `Last` are held stable while `M_Valid & !M_Ready`.
- FIFO full cannot occur: `S_Ready` deasserts first. Simultaneous read and write at any occupancy preserves the count.
- FIFO wrap-around is pointer modulo depth, with no bubble.
- A reset mid-frame clears the FIFO, all counters and the state immediately, with no output. The next Start behaves as after power-up.
- Start during RUN or DRAIN is ignored; the current config is unaffected.
- Ragged edges: C = 5, S = 2 keeps columns 0, 2 and 4, so out_cols = 3.

## Structure
- Shared package `stride_pkg`:
  - Stride codes `STRIDE_1`, `STRIDE_2`, `STRIDE_4`, `STRIDE_RSVD`.
  - Function `ceil_div_pow2(n, code)`.
  - State encodings `ST_IDLE`, `ST_RUN`, `ST_DRAIN`.
- One sub-module, `stride_sync_fifo`: a show-ahead synchronous FIFO with parameters width and `FIFO_ADDR_BITS`, exposing a free-count output. Async active-low reset.
- The top level holds the FSM, the input counters, the keep logic, the register stage and the output counters/`Last`.

## Test plan
- S = 2, R = C = 4, CT = 2, 32 beats, `M_Ready` = 1 → 8 output beats: pixels (0,0), (0,2), (2,0), (2,2), two groups each. `Last` on beat 8. `Stride_Complete` once.
- S = 4, R = 5, C = 6, CT = 1 → out_rows = 2, out_cols = 2, giving 4 beats at pixels (0,0), (0,4), (4,0), (4,4). `Last` on the 4th.
- S = 1, R = C = 3, CT = 1, with `M_Ready` held 0 → `S_Ready` drops at FIFO free < 2 and no beat is lost. On releasing `M_Ready`, 9 beats come out in order.
- Random `S_Valid`/`M_Ready` toggling, S = 2, R = C = 8, CT = 4 → 64 beats, matching a scoreboard bit-exactly. `Last` appears only on the 64th.
- Start with Stride_REG = 3 (or R = 0) → `Cfg_Err` pulse, `Busy` stays 0, `S_Ready` stays 0.
- Assert `rst` = 0 mid-RUN after 10 beats → all outputs 0 and FIFO empty. A fresh Start with S = 2, R = C = 2, CT = 1 yields exactly 1 beat with `Last`.
